// File: rtl/wb_arbiter_pkg.sv
// Shared types and the round-robin pick function for the Wishbone per-slave arbiters.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TERR  = 2'd2
    } state_t;

    localparam int unsigned MAX_MASTERS = 16;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } pick_t;

    // Scan from last_id+1 upward, wrapping modulo n; the first set request wins.
    function automatic pick_t rr_pick(input logic [15:0] req, input logic [3:0] last_id,
                                      input int unsigned n);
        pick_t      r;
        logic [3:0] j;
        r = '0;
        for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
            if (i <= n && !r.valid) begin
                j = 4'((int'(last_id) + int'(i)) % int'(n));
                if (req[j]) begin
                    r.valid = 1'b1;
                    r.idx   = j;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: next requester after last_id, wrapping.
module wb_arbiter_rr_pick
    import wb_arbiter_pkg::*;
#(
    parameter int N_MASTERS       = 2,
    parameter int N_MASTERID_BITS = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic [N_MASTERS-1:0]       req,
    input  logic [N_MASTERID_BITS-1:0] last_id,
    output logic [N_MASTERID_BITS-1:0] pick_id,
    output logic                       pick_valid
);

    pick_t r;

    always_comb begin
        r          = rr_pick(16'(req), 4'(last_id), N_MASTERS);
        pick_id    = N_MASTERID_BITS'(r.idx);
        pick_valid = r.valid;
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Per-slave round-robin Wishbone arbiter with bus lock for the whole CYC.
// Optional stall watchdog enabled by defining WB_ARBITER_RR_TIMEOUT_EN.
module wb_arbiter_rr
    import wb_arbiter_pkg::*;
#(
    parameter int N_MASTERS       = 2,
    parameter int N_MASTERID_BITS = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_MASTERS-1:0]       cyc_i,
    input  logic [N_MASTERS-1:0]       stb_i,
    input  logic                       ack_i,
    input  logic                       err_i,
    output logic [N_MASTERS-1:0]       gnt_o,
    output logic [N_MASTERID_BITS-1:0] gnt_id_o,
    output logic                       gnt_valid_o,
    output logic                       to_err_o
);

    localparam logic [N_MASTERID_BITS-1:0] LAST_RESET = N_MASTERID_BITS'(N_MASTERS - 1);

    state_t                     state_q, state_d;
    logic [N_MASTERS-1:0]       gnt_q, gnt_d;
    logic [N_MASTERID_BITS-1:0] id_q, id_d;
    logic [N_MASTERID_BITS-1:0] last_q, last_d;
    logic [N_MASTERID_BITS-1:0] pick_id;
    logic                       pick_valid;

    wb_arbiter_rr_pick #(
        .N_MASTERS      (N_MASTERS),
        .N_MASTERID_BITS(N_MASTERID_BITS)
    ) u_pick (
        .req       (cyc_i),
        .last_id   (last_q),
        .pick_id   (pick_id),
        .pick_valid(pick_valid)
    );

`ifdef WB_ARBITER_RR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;
    assign stall = stb_i[id_q] & ~ack_i & ~err_i;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, stb_i, ack_i, err_i, (TIMEOUT_CYCLES > 0)};
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
`ifdef WB_ARBITER_RR_TIMEOUT_EN
        cnt_d   = '0;
`endif
        if (state_q == IDLE) begin
            if (pick_valid) begin
                state_d = GRANT;
                gnt_d   = N_MASTERS'(1) << pick_id;
                id_d    = pick_id;
                last_d  = pick_id;
            end
        end else if (cyc_i[id_q]) begin
            // Lock held: a CYC that fell and rose within one cycle looks held too.
            state_d = GRANT;
`ifdef WB_ARBITER_RR_TIMEOUT_EN
            if (state_q == GRANT && stall) begin
                if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = TERR;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
        end else if (pick_valid) begin
            state_d = GRANT;
            gnt_d   = N_MASTERS'(1) << pick_id;
            id_d    = pick_id;
            last_d  = pick_id;
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= LAST_RESET;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARBITER_RR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign to_err_o = (state_q == TERR);
`else
    assign to_err_o = 1'b0;
`endif

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = id_q;
    assign gnt_valid_o = |gnt_q;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: a 2-master instance and a 4-master instance.
module tb_wb_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cyc = '0, stb = '0;
    logic       ack = 1'b0, err = 1'b0;
    logic [1:0] gnt;
    logic [0:0] gnt_id;
    logic       gnt_valid, to_err;

    logic [3:0] cyc4 = '0, stb4 = '0;
    logic [3:0] gnt4;
    logic [1:0] gnt_id4;
    logic       gnt_valid4, to_err4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter_rr #(.N_MASTERS(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .ack_i(ack), .err_i(err),
        .gnt_o(gnt), .gnt_id_o(gnt_id), .gnt_valid_o(gnt_valid), .to_err_o(to_err)
    );

    wb_arbiter_rr #(.N_MASTERS(4), .TIMEOUT_CYCLES(8)) dut4 (
        .clk(clk), .rst(rst), .cyc_i(cyc4), .stb_i(stb4), .ack_i(1'b0), .err_i(1'b0),
        .gnt_o(gnt4), .gnt_id_o(gnt_id4), .gnt_valid_o(gnt_valid4), .to_err_o(to_err4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({gnt, gnt_id, gnt_valid, to_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset: gnt=%b id=%b valid=%b to_err=%b, want all 0", gnt, gnt_id, gnt_valid, to_err);
        end
        checks++;
        if ({gnt4, gnt_id4, gnt_valid4, to_err4} !== 8'b0) begin
            errors++;
            $display("FAIL reset4: gnt=%b id=%b valid=%b to_err=%b, want all 0", gnt4, gnt_id4, gnt_valid4, to_err4);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_grant();
        cyc = 2'b11;
        step();
        checks++;
        if (gnt !== 2'b01 || gnt_id !== 1'b0 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: gnt=%b id=%b valid=%b, want 01 0 1", gnt, gnt_id, gnt_valid);
        end
    endtask

    task automatic test_lock_and_handover();
        for (int i = 0; i < 4; i++) begin
            stb = 2'(i);
            step();
            checks++;
            if (gnt !== 2'b01 || to_err !== 1'b0) begin
                errors++;
                $display("FAIL lock_%0d: gnt=%b to_err=%b, want 01 0", i, gnt, to_err);
            end
        end
        stb = 2'b00;
        cyc = 2'b10;
        step();
        checks++;
        if (gnt !== 2'b10 || gnt_id !== 1'b1 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL handover: gnt=%b id=%b valid=%b, want 10 1 1", gnt, gnt_id, gnt_valid);
        end
        cyc = 2'b00;
        step();
        checks++;
        if (gnt !== 2'b00 || gnt_id !== 1'b0 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: gnt=%b id=%b valid=%b, want 00 0 0", gnt, gnt_id, gnt_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_id;
        cyc = 2'b11;
        step();
        exp_id = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (gnt_id !== exp_id || gnt !== (2'b01 << exp_id) || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_seq_%0d: gnt=%b id=%b, want id %b", i, gnt, gnt_id, exp_id);
            end
            ack = 1'b1;
            step();
            ack = 1'b0;
            cyc = exp_id ? 2'b01 : 2'b10;
            step();
            cyc = 2'b11;
            exp_id = ~exp_id;
        end
    endtask

    task automatic test_reset_mid_grant();
        cyc = 2'b10;
        step();
        cyc = 2'b11;
        step();
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset_grant: gnt=%b, want 10", gnt);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({gnt, gnt_id, gnt_valid, to_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_grant: gnt=%b id=%b valid=%b, want all 0", gnt, gnt_id, gnt_valid);
        end
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 2'b01 || gnt_id !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_grant: gnt=%b id=%b, want 01 0", gnt, gnt_id);
        end
        cyc = 2'b00;
        step();
    endtask

    task automatic test_n4_wrap();
        cyc4 = 4'b0100;
        step();
        checks++;
        if (gnt4 !== 4'b0100 || gnt_id4 !== 2'd2) begin
            errors++;
            $display("FAIL n4_first: gnt=%b id=%0d, want 0100 2", gnt4, gnt_id4);
        end
        cyc4 = 4'b0000;
        step();
        cyc4 = 4'b0101;
        step();
        checks++;
        if (gnt4 !== 4'b0001 || gnt_id4 !== 2'd0) begin
            errors++;
            $display("FAIL n4_wrap: gnt=%b id=%0d, want 0001 0", gnt4, gnt_id4);
        end
        cyc4 = 4'b0100;
        step();
        checks++;
        if (gnt4 !== 4'b0100 || gnt_id4 !== 2'd2) begin
            errors++;
            $display("FAIL n4_next: gnt=%b id=%0d, want 0100 2", gnt4, gnt_id4);
        end
        cyc4 = 4'b0101;
        step();
        checks++;
        if (gnt4 !== 4'b0100 || gnt_valid4 !== 1'b1) begin
            errors++;
            $display("FAIL n4_hold: gnt=%b valid=%b, want 0100 1", gnt4, gnt_valid4);
        end
        cyc4 = 4'b0000;
        step();
    endtask

    task automatic test_watchdog();
        logic exp_err;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 2'b01;
        stb = 2'b01;
        step();
        for (int i = 1; i <= 9; i++) begin
            step();
`ifdef WB_ARBITER_RR_TIMEOUT_EN
            exp_err = (i == 8);
`else
            exp_err = 1'b0;
`endif
            checks++;
            if (to_err !== exp_err || gnt !== 2'b01) begin
                errors++;
                $display("FAIL wd_stall_%0d: to_err=%b gnt=%b, want %b 01", i, to_err, gnt, exp_err);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 1; i <= 10; i++) begin
            ack = (i == 8);
            step();
            checks++;
            if (to_err !== 1'b0 || gnt !== 2'b01) begin
                errors++;
                $display("FAIL wd_ack_%0d: to_err=%b gnt=%b, want 0 01", i, to_err, gnt);
            end
        end
        ack = 1'b0;
        stb = 2'b00;
        cyc = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_lock_and_handover();
        test_back_to_back();
        test_reset_mid_grant();
        test_n4_wrap();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
